fan_ctrl_multi: RTL and testbench

- Multi-channel fan controller for the control board fan header group: one shared PWM output and N tachometer inputs.
- Generalises the fixed single-PWM, 6-tach wiring into a parametrised block. Adds per-channel RPM pulse counting, a measurement gate, stall detection and a programmable duty cycle.
- Sits between the register interface (PS side) and the fan pins in bank 35.

---
 rtl/fan_pkg.sv | 21 ++
 rtl/fan_tach_chan.sv | 85 ++++++++
 rtl/fan_ctrl_multi.sv | 107 ++++++++++
 tb/tb_fan_ctrl_multi.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/fan_pkg.sv
// Shared helpers for the fan controller: width/prescaler math and default sizes.
package fan_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int DUTY_MAX  = 255;

  typedef logic [CNT_W_DEF-1:0] tach_cnt_t;

  function automatic int clog2(input longint value);
    int bits = 0;
    for (longint x = value - 1; x > 0; x = x >> 1) bits++;
    return bits;
  endfunction

  // Clocks per PWM counter step; never below one so the PWM always advances.
  function automatic int presc_calc(input longint clk_hz, input longint pwm_hz, input int pwm_bits);
    longint p = clk_hz / (pwm_hz * (longint'(1) << pwm_bits));
    return (p < 1) ? 1 : int'(p);
  endfunction

endpackage

// File: rtl/fan_tach_chan.sv
// One tach channel: synchroniser, glitch filter, rising-edge counter with
// saturation, and zero-window stall tracking, all evaluated at each gate latch.
import fan_pkg::*;

module fan_tach_chan #(
  parameter int CNT_W     = 16,
  parameter int FILT_LEN  = 4,
  parameter int STALL_WIN = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tach,
  input  logic             latch,
  output logic [CNT_W-1:0] count,
  output logic             stall,
  output logic             stall_next
);

  localparam int FW = (clog2(FILT_LEN) < 1) ? 1 : clog2(FILT_LEN);
  localparam int ZW = (clog2(STALL_WIN + 1) < 1) ? 1 : clog2(STALL_WIN + 1);

  logic             sync1, sync2, filt, filt_prev, rise;
  logic [FW-1:0]    filt_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic [ZW-1:0]    zwin, zwin_next;

  assign rise = filt & ~filt_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      filt      <= 1'b0;
      filt_prev <= 1'b0;
      filt_cnt  <= '0;
    end else begin
      sync1     <= tach;
      sync2     <= sync1;
      filt_prev <= filt;
      // Counts consecutive samples that disagree with the accepted level.
      if (sync2 == filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILT_LEN - 1)) begin
        filt     <= sync2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    zwin_next  = zwin;
    stall_next = stall;
    if (latch) begin
      if (edge_cnt == '0) begin
        if (zwin != ZW'(STALL_WIN)) zwin_next = zwin + 1'b1;
        if (zwin_next == ZW'(STALL_WIN)) stall_next = 1'b1;
      end else begin
        zwin_next  = '0;
        stall_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cnt <= '0;
      count    <= '0;
      zwin     <= '0;
      stall    <= 1'b0;
    end else begin
      zwin  <= zwin_next;
      stall <= stall_next;
      if (latch) begin
        count    <= edge_cnt;
        // An edge on the terminal cycle belongs to the window just starting.
        edge_cnt <= rise ? CNT_W'(1) : '0;
      end else if (rise && !(&edge_cnt)) begin
        edge_cnt <= edge_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fan_ctrl_multi.sv
// Shared-PWM fan controller with N tach channels. Define FAN_FAILSAFE_EN to force
// pwm_o high while any channel reports a stall.
import fan_pkg::*;

module fan_ctrl_multi #(
  parameter int CLK_HZ      = 100_000_000,
  parameter int PWM_FREQ_HZ = 25_000,
  parameter int PWM_BITS    = clog2(DUTY_MAX + 1),
  parameter int N_FAN       = 6,
  parameter int CNT_W       = $bits(tach_cnt_t),
  parameter int GATE_CYC    = 100_000_000,
  parameter int FILT_LEN    = 4,
  parameter int STALL_WIN   = 2,
  parameter int DUTY_RST    = (2 ** PWM_BITS) - 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PWM_BITS-1:0]    duty_i,
  input  logic                   duty_we,
  output logic                   pwm_o,
  input  logic [N_FAN-1:0]       tach_i,
  output logic [N_FAN*CNT_W-1:0] tach_cnt_o,
  output logic                   meas_valid_o,
  output logic [N_FAN-1:0]       stall_o,
  output logic                   any_stall_o
);

  localparam int PRESC   = presc_calc(CLK_HZ, PWM_FREQ_HZ, PWM_BITS);
  localparam int PRESC_W = (clog2(PRESC) < 1) ? 1 : clog2(PRESC);
  localparam int GATE_W  = (clog2(GATE_CYC) < 1) ? 1 : clog2(GATE_CYC);
  localparam logic [PWM_BITS-1:0] DUTY_FULL = '1;

  logic [PRESC_W-1:0]  presc_cnt;
  logic [PWM_BITS-1:0] pwm_cnt, duty_shadow, duty_active;
  logic [GATE_W-1:0]   gate_cnt;
  logic [N_FAN-1:0]    stall_next;
  logic                tick, wrap, latch, pwm_d;

  assign tick  = (presc_cnt == PRESC_W'(PRESC - 1));
  assign wrap  = tick && (pwm_cnt == DUTY_FULL);
  assign latch = (gate_cnt == GATE_W'(GATE_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_cnt   <= '0;
      pwm_cnt     <= '0;
      duty_shadow <= PWM_BITS'(DUTY_RST);
      duty_active <= PWM_BITS'(DUTY_RST);
    end else begin
      presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
      if (tick) pwm_cnt <= pwm_cnt + 1'b1;
      if (duty_we) duty_shadow <= duty_i;
      // Only swap duty at a period boundary so a period is never truncated.
      if (wrap) duty_active <= duty_we ? duty_i : duty_shadow;
    end
  end

`ifdef FAN_FAILSAFE_EN
  logic fs_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              fs_hold <= 1'b0;
    else if (any_stall_o) fs_hold <= 1'b1;
    else if (wrap)        fs_hold <= 1'b0;
  end

  always_comb begin
    pwm_d = (pwm_cnt < duty_active) || (duty_active == DUTY_FULL);
    if (any_stall_o || fs_hold) pwm_d = 1'b1;
  end
`else
  always_comb begin
    pwm_d = (pwm_cnt < duty_active) || (duty_active == DUTY_FULL);
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_o        <= 1'b1;
      gate_cnt     <= '0;
      meas_valid_o <= 1'b0;
      any_stall_o  <= 1'b0;
    end else begin
      pwm_o        <= pwm_d;
      gate_cnt     <= latch ? '0 : gate_cnt + 1'b1;
      meas_valid_o <= latch;
      any_stall_o  <= |stall_next;
    end
  end

  for (genvar gi = 0; gi < N_FAN; gi++) begin : g_chan
    fan_tach_chan #(
      .CNT_W     (CNT_W),
      .FILT_LEN  (FILT_LEN),
      .STALL_WIN (STALL_WIN)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .tach       (tach_i[gi]),
      .latch      (latch),
      .count      (tach_cnt_o[gi*CNT_W +: CNT_W]),
      .stall      (stall_o[gi]),
      .stall_next (stall_next[gi])
    );
  end

endmodule

// File: tb/tb_fan_ctrl_multi.sv
// Scoreboard bench for fan_ctrl_multi: random tach pulse trains and duty writes,
// expected window results and PWM high-times derived from counting rules.
module tb_fan_ctrl_multi;

  localparam int N    = 6;
  localparam int CW   = 8;
  localparam int GATE = 10_000;
  localparam int PER  = 256;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [7:0]      duty_i = '0;
  logic            duty_we = 1'b0;
  logic            pwm_o;
  logic [N-1:0]    tach_i = '0;
  logic [N*CW-1:0] tach_cnt_o;
  logic            meas_valid_o;
  logic [N-1:0]    stall_o;
  logic            any_stall_o;

  always #5 clk = ~clk;

  fan_ctrl_multi #(
    .CLK_HZ(2_560_000), .PWM_FREQ_HZ(10_000), .PWM_BITS(8), .N_FAN(N), .CNT_W(CW),
    .GATE_CYC(GATE), .FILT_LEN(4), .STALL_WIN(2), .DUTY_RST(255)
  ) dut (
    .clk(clk), .rst(rst), .duty_i(duty_i), .duty_we(duty_we), .pwm_o(pwm_o),
    .tach_i(tach_i), .tach_cnt_o(tach_cnt_o), .meas_valid_o(meas_valid_o),
    .stall_o(stall_o), .any_stall_o(any_stall_o)
  );

  // Clock edges since reset release; after edge k the value is k.
  int cyc = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
  endtask

  typedef struct { logic [N*CW-1:0] cnt; logic [N-1:0] stall; } exp_t;
  typedef struct { int eff; int val; } dw_t;

  exp_t meas_q[$];
  dw_t  duty_q[$];
  int   cur_duty = 255;
  int   zrun[N];
  int   k[N], h[N], off[N], g[N];

  // Window results monitor.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && meas_valid_o) begin
      if (meas_q.size() == 0) begin
        chk("meas_unexpected", 64'd1, 64'd0);
      end else begin
        e = meas_q.pop_front();
        $display("window result at cycle %0d: counts %0h stall %b", cyc, tach_cnt_o, stall_o);
        chk("tach_cnt", tach_cnt_o, e.cnt);
        chk("stall", stall_o, e.stall);
        chk("any_stall", any_stall_o, |e.stall);
        chk("meas_time", cyc % GATE, 0);
      end
    end
  end

  // PWM monitor: high cycles per 256-cycle period versus the duty active for it.
  int hi = 0;
  always @(negedge clk) begin
    int p;
    dw_t d;
    if (rst) begin
      hi = 0;
    end else if (cyc >= 1) begin
      hi += int'(pwm_o);
      if (cyc % PER == 0) begin
        p = cyc / PER - 1;
        while (duty_q.size() > 0 && duty_q[0].eff <= p) begin
          d = duty_q.pop_front();
          cur_duty = d.val;
        end
        chk("pwm_high", hi, (cur_duty == 255) ? 256 : cur_duty);
        hi = 0;
      end
    end
  end

  // kind 0: no pulses (glitches only); 1: random; 2: channel 0 saturating, channel 1 active.
  task automatic plan_window(input int kind);
    for (int c = 0; c < N; c++) begin
      h[c]   = 5 + $urandom_range(0, 10);
      off[c] = 50 + $urandom_range(0, 2950);
      g[c]   = $urandom_range(1, 3);
      if (kind == 0) k[c] = 0;
      else k[c] = ($urandom_range(0, 9) < 3) ? 0 : $urandom_range(1, 25);
    end
    if (kind == 2) begin
      k[0] = 300; h[0] = 10; off[0] = 100;
      if (k[1] == 0) k[1] = $urandom_range(1, 25);
    end
  endtask

  task automatic push_expected();
    exp_t e;
    for (int c = 0; c < N; c++) begin
      int n;
      n = (k[c] > 255) ? 255 : k[c];
      e.cnt[c*CW +: CW] = CW'(n);
      zrun[c] = (k[c] == 0) ? zrun[c] + 1 : 0;
      e.stall[c] = (zrun[c] >= 2);
    end
    meas_q.push_back(e);
  endtask

  // Tach level at window offset t: k pulses of half-period h, or a short glitch.
  function automatic logic level(input int c, input int t);
    int rel;
    rel = t - off[c];
    if (k[c] == 0) return (rel >= 0) && (rel < g[c]);
    return (rel >= 0) && (rel < k[c] * 2 * h[c]) && ((rel % (2 * h[c])) < h[c]);
  endfunction

  task automatic drive_window(input int stop_at);
    for (int t = 0; t < GATE; t++) begin
      if (t == stop_at) return;
      for (int c = 0; c < N; c++) tach_i[c] = level(c, t);
      duty_we = 1'b0;
      if (t % 2500 == 1234) begin
        case ($urandom_range(0, 3))
          0:       duty_i = 8'd0;
          1:       duty_i = 8'd64;
          2:       duty_i = 8'd255;
          default: duty_i = 8'($urandom_range(0, 255));
        endcase
        duty_we = 1'b1;
        duty_q.push_back('{(cyc + PER) / PER, int'(duty_i)});
        $display("duty write %0d at cycle %0d", duty_i, cyc);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    for (int c = 0; c < N; c++) zrun[c] = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    plan_window(0); push_expected(); drive_window(GATE);
    plan_window(0); push_expected(); drive_window(GATE);
    plan_window(2); push_expected(); drive_window(GATE);
    plan_window(1); push_expected(); drive_window(GATE);
    plan_window(1); push_expected(); drive_window(GATE);

    // Reset in the middle of a window with edges already counted.
    plan_window(1); drive_window(4000);
    rst = 1'b1;
    #1;
    chk("rst_pwm", pwm_o, 1);
    chk("rst_tach_cnt", tach_cnt_o, 0);
    chk("rst_meas_valid", meas_valid_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_any_stall", any_stall_o, 0);
    meas_q.delete();
    duty_q.delete();
    cur_duty = 255;
    for (int c = 0; c < N; c++) zrun[c] = 0;
    tach_i  = '0;
    duty_we = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    plan_window(1); push_expected(); drive_window(GATE);
    for (int i = 0; i < 20 && meas_q.size() > 0; i++) @(negedge clk);
    chk("meas_drain", meas_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
